// File: rtl/cic_decimator.sv
// CIC decimation filter: STAGES integrators at the input rate, a programmable
// decimation counter, STAGES combs at the decimated rate and a registered
// output scaler. Optional macro CIC_ROUND_EN selects round-half-up with
// positive saturation instead of truncation on the output shift.
module cic_decimator #(
  parameter int IN_WIDTH     = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int STAGES       = 3,
  parameter int MAX_RATE     = 4,
  parameter int DEFAULT_RATE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_valid,
  input  logic [$clog2(MAX_RATE):0]    rate,
  input  logic                         rate_load,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid
);

  localparam int RATE_W    = $clog2(MAX_RATE) + 1;
  localparam int ACC_WIDTH = IN_WIDTH + STAGES * $clog2(MAX_RATE);
  localparam int SHIFT     = (ACC_WIDTH > OUT_WIDTH) ? (ACC_WIDTH - OUT_WIDTH) : 0;

  logic [RATE_W-1:0]    active_rate;
  logic [RATE_W-1:0]    count;
  logic                 rate_ok;
  logic                 load_ok;
  logic                 strobe;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] integ   [STAGES];
  logic [ACC_WIDTH-1:0] comb    [STAGES];
  logic [ACC_WIDTH-1:0] dly     [STAGES];
  logic [ACC_WIDTH-1:0] comb_in [STAGES];
  logic [STAGES:0]      stb;
  logic [ACC_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] out_next;

  // Rate qualification and decimation strobe generation.
  always_comb begin
    rate_ok = (rate >= RATE_W'(2)) && (rate <= RATE_W'(MAX_RATE));
    load_ok = rate_load && rate_ok;
    // A valid rate load restarts the group, so that edge can never strobe.
    strobe  = in_valid && !load_ok && (count == active_rate - RATE_W'(1));
    in_ext  = ACC_WIDTH'($signed(in_data));
  end

  // Active ratio register and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_rate <= RATE_W'(DEFAULT_RATE);
      count       <= '0;
    end else if (load_ok) begin
      active_rate <= rate;
      count       <= in_valid ? RATE_W'(1) : '0;
    end else if (in_valid) begin
      count <= strobe ? '0 : count + RATE_W'(1);
    end
  end

  // Integrator cascade; each stage adds the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + in_ext;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Strobe pipeline: bit k enables comb stage k, bit STAGES loads the output.
  always_ff @(posedge clk) begin
    if (rst) stb <= '0;
    else     stb <= {stb[STAGES-1:0], strobe};
  end

  // Comb stage inputs.
  always_comb begin
    comb_in[0] = integ[STAGES-1];
    for (int k = 1; k < STAGES; k++) comb_in[k] = comb[k-1];
  end

  // Comb cascade with unit differential delay, advanced only by strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stb[k]) begin
          comb[k] <= comb_in[k] - dly[k];
          dly[k]  <= comb_in[k];
        end
      end
    end
  end

`ifdef CIC_ROUND_EN
  localparam int                 HALF_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [ACC_WIDTH:0] HALF    = (ACC_WIDTH + 1)'(1) << HALF_SH;
  localparam logic [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  logic [ACC_WIDTH:0] rnd;
  logic [ACC_WIDTH:0] rnd_sh;
`endif

  // Output scaling: arithmetic shift, optionally rounded and saturated.
  always_comb begin
    acc      = comb[STAGES-1];
    out_next = OUT_WIDTH'($signed(acc) >>> SHIFT);
`ifdef CIC_ROUND_EN
    // One guard bit keeps the half-LSB addition from wrapping.
    rnd    = {acc[ACC_WIDTH-1], acc} + HALF;
    rnd_sh = $signed(rnd) >>> SHIFT;
    if (SHIFT > 0) begin
      if (!rnd_sh[ACC_WIDTH] && (rnd_sh > OUT_MAX)) out_next = OUT_MAX[OUT_WIDTH-1:0];
      else                                          out_next = OUT_WIDTH'(rnd_sh);
    end
`endif
  end

  // Registered output; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stb[STAGES];
      if (stb[STAGES]) out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator (default parameters). Expected outputs
// come from a sample-domain model: S-fold running sum of accepted samples,
// decimated at group ends, S-fold first difference, then wrap and scale.
module tb_cic_decimator;

  localparam int S     = 3;
  localparam int ACC   = 14;
  localparam int SHIFT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [2:0] rate = '0;
  logic       rate_load = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;

  cic_decimator #(
    .IN_WIDTH    (8),
    .OUT_WIDTH   (8),
    .STAGES      (3),
    .MAX_RATE    (4),
    .DEFAULT_RATE(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .rate     (rate),
    .rate_load(rate_load),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     m_rate = 4;
  int     m_cnt = 0;
  longint xs[$];
  int     grp_end[$];
  int     exp_cyc[$];
  int     obs_cyc[$];
  longint obs_data[$];

  // Expected output sequence for everything accepted since the last reset.
  function automatic void model_out(output longint res[$]);
    longint y[$];
    longint w[$];
    longint v;
    longint mask;
    res.delete();
    y = xs;
    mask = (longint'(1) << ACC) - 1;
    for (int s = 0; s < S; s++)
      for (int i = 1; i < y.size(); i++) y[i] = y[i] + y[i-1];
    foreach (grp_end[d]) begin
      int idx = grp_end[d] - (S - 1);
      w.push_back((idx >= 0) ? y[idx] : 0);
    end
    for (int s = 0; s < S; s++)
      for (int d = w.size() - 1; d >= 0; d--) w[d] = w[d] - ((d > 0) ? w[d-1] : 0);
    foreach (w[d]) begin
      v = w[d] & mask;
      if (v >= (longint'(1) << (ACC - 1))) v = v - (longint'(1) << ACC);
`ifdef CIC_ROUND_EN
      v = (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      if (v > 127) v = 127;
`else
      v = v >>> SHIFT;
`endif
      res.push_back(v);
    end
  endfunction

  task automatic step(input logic v, input int d, input logic ld, input int r);
    in_valid  = v;
    in_data   = 8'(d);
    rate_load = ld;
    rate      = 3'(r);
    if (ld && r >= 2 && r <= 4) begin
      m_rate = r;
      m_cnt  = 0;
      if (v) begin
        xs.push_back(longint'($signed(8'(d))));
        m_cnt = 1;
      end
    end else if (v) begin
      xs.push_back(longint'($signed(8'(d))));
      if (m_cnt == m_rate - 1) begin
        m_cnt = 0;
        grp_end.push_back(xs.size() - 1);
        exp_cyc.push_back(cyc + 1 + S + 1);
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      obs_cyc.push_back(cyc);
      obs_data.push_back(longint'($signed(out_data)));
    end
  endtask

  task automatic do_reset(input logic v, input logic ld, input int r);
    rst       = 1'b1;
    in_valid  = v;
    in_data   = 8'($urandom);
    rate_load = ld;
    rate      = 3'(r);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    in_valid = 1'b0;
    rate_load = 1'b0;
    xs.delete(); grp_end.delete(); exp_cyc.delete();
    obs_cyc.delete(); obs_data.delete();
    m_rate = 4;
    m_cnt  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset;
    do_reset(1'b1, 1'b1, 2);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'd0) begin
      n_err++; $display("FAIL reset_data: got %0d expected 0", out_data);
    end
  endtask

  // DC input every cycle at the default rate 4.
  task automatic test_dc(input int val, input int n);
    longint res[$];
    int c0;
    do_reset(1'b0, 1'b0, 0);
    c0 = cyc;
    for (int i = 0; i < n; i++) step(1'b1, val, 1'b0, 0);
    idle(S + 3);
    model_out(res);
    n_cmp++;
    if (obs_cyc.size() !== n / 4) begin
      n_err++; $display("FAIL dc_count: got %0d expected %0d", obs_cyc.size(), n / 4);
    end
    if (obs_cyc.size() > 0) begin
      n_cmp++;
      if (obs_cyc[0] !== c0 + 8) begin
        n_err++; $display("FAIL dc_first_pulse: got %0d expected %0d", obs_cyc[0], c0 + 8);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] !== 4) begin
        n_err++; $display("FAIL dc_spacing[%0d]: got %0d expected 4", i, obs_cyc[i] - obs_cyc[i-1]);
      end
    end
    for (int i = 0; i < obs_data.size() && i < res.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== res[i]) begin
        n_err++; $display("FAIL dc_model[%0d]: got %0d expected %0d", i, obs_data[i], res[i]);
      end
      if (i > S) begin
        n_cmp++;
        if (obs_data[i] !== longint'(val)) begin
          n_err++; $display("FAIL dc_settled[%0d]: got %0d expected %0d", i, obs_data[i], val);
        end
      end
    end
    idle(5);
    if (res.size() > 0) begin
      n_cmp++;
      if (longint'($signed(out_data)) !== res[res.size()-1]) begin
        n_err++;
        $display("FAIL dc_hold: got %0d expected %0d", $signed(out_data), res[res.size()-1]);
      end
    end
  endtask

  // Rate 2 with DC 64, then an illegal load of 5 that must be ignored.
  task automatic test_rate_change;
    longint res[$];
    do_reset(1'b0, 1'b0, 0);
    step(1'b1, 64, 1'b1, 2);
    for (int i = 0; i < 19; i++) step(1'b1, 64, 1'b0, 0);
    step(1'b1, 64, 1'b1, 5);
    for (int i = 0; i < 19; i++) step(1'b1, 64, 1'b0, 0);
    idle(S + 3);
    model_out(res);
    n_cmp++;
    if (obs_cyc.size() !== 20) begin
      n_err++; $display("FAIL rate_count: got %0d expected 20", obs_cyc.size());
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] !== 2) begin
        n_err++; $display("FAIL rate_spacing[%0d]: got %0d expected 2", i, obs_cyc[i] - obs_cyc[i-1]);
      end
    end
    for (int i = 0; i < obs_data.size() && i < res.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== res[i]) begin
        n_err++; $display("FAIL rate_model[%0d]: got %0d expected %0d", i, obs_data[i], res[i]);
      end
      if (i > S) begin
        n_cmp++;
        if (obs_data[i] !== 64'sd8) begin
          n_err++; $display("FAIL rate_settled[%0d]: got %0d expected 8", i, obs_data[i]);
        end
      end
    end
  endtask

  // Small DC at rate 2 exercises truncation versus rounding.
  task automatic test_small_dc(input int val, input int expv);
    do_reset(1'b0, 1'b0, 0);
    step(1'b1, val, 1'b1, 2);
    for (int i = 0; i < 23; i++) step(1'b1, val, 1'b0, 0);
    idle(S + 3);
    n_cmp++;
    if (obs_data.size() !== 12) begin
      n_err++; $display("FAIL small_count: got %0d expected 12", obs_data.size());
    end
    for (int i = S + 1; i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== longint'(expv)) begin
        n_err++; $display("FAIL small_dc[%0d]: got %0d expected %0d", i, obs_data[i], expv);
      end
    end
  endtask

  // in_valid every other cycle at rate 4.
  task automatic test_gapped;
    longint res[$];
    do_reset(1'b0, 1'b0, 0);
    for (int i = 0; i < 48; i++) step(i[0] == 1'b0, 16, 1'b0, 0);
    idle(S + 3);
    model_out(res);
    n_cmp++;
    if (obs_cyc.size() !== 6) begin
      n_err++; $display("FAIL gap_count: got %0d expected 6", obs_cyc.size());
    end
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
      n_cmp++;
      if (obs_cyc[i] !== exp_cyc[i]) begin
        n_err++; $display("FAIL gap_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], exp_cyc[i]);
      end
    end
    for (int i = 0; i < obs_data.size() && i < res.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== res[i]) begin
        n_err++; $display("FAIL gap_model[%0d]: got %0d expected %0d", i, obs_data[i], res[i]);
      end
      if (i > S) begin
        n_cmp++;
        if (obs_data[i] !== 64'sd16) begin
          n_err++; $display("FAIL gap_settled[%0d]: got %0d expected 16", i, obs_data[i]);
        end
      end
    end
  endtask

  // Reset two samples into a group with a strobe still in the comb pipeline.
  task automatic test_reset_mid;
    int guard;
    do_reset(1'b0, 1'b0, 0);
    step(1'b1, 50, 1'b1, 3);
    for (int i = 0; i < 20; i++) step(1'b1, 50, 1'b0, 0);
    guard = 0;
    while (m_cnt != 0 && guard < 10) begin
      step(1'b1, 50, 1'b0, 0);
      guard++;
    end
    step(1'b1, 50, 1'b0, 0);
    step(1'b1, 50, 1'b0, 0);
    do_reset(1'b1, 1'b1, 2);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'd0) begin
      n_err++; $display("FAIL mid_reset_data: got %0d expected 0", out_data);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 50, 1'b0, 0);
    idle(8);
    n_cmp++;
    if (obs_cyc.size() !== 0) begin
      n_err++; $display("FAIL mid_early_pulse: got %0d expected 0", obs_cyc.size());
    end
    step(1'b1, 50, 1'b0, 0);
    idle(S + 3);
    n_cmp++;
    if (obs_cyc.size() !== 1) begin
      n_err++; $display("FAIL mid_pulse_count: got %0d expected 1", obs_cyc.size());
    end else begin
      n_cmp++;
      if (obs_cyc[0] !== exp_cyc[0]) begin
        n_err++; $display("FAIL mid_pulse_cycle: got %0d expected %0d", obs_cyc[0], exp_cyc[0]);
      end
    end
  endtask

  // Random data, random valid gaps and random (sometimes illegal) rate loads.
  task automatic test_random;
    longint res[$];
    do_reset(1'b0, 1'b0, 0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
           $urandom_range(0, 29) == 0, int'($urandom_range(0, 7)));
    idle(S + 3);
    model_out(res);
    n_cmp++;
    if (obs_cyc.size() !== exp_cyc.size()) begin
      n_err++; $display("FAIL rand_count: got %0d expected %0d", obs_cyc.size(), exp_cyc.size());
    end
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
      n_cmp++;
      if (obs_cyc[i] !== exp_cyc[i]) begin
        n_err++; $display("FAIL rand_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], exp_cyc[i]);
      end
    end
    for (int i = 0; i < obs_data.size() && i < res.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== res[i]) begin
        n_err++; $display("FAIL rand_data[%0d]: got %0d expected %0d", i, obs_data[i], res[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc(16, 40);
    test_dc(-128, 2000);
    test_rate_change();
`ifdef CIC_ROUND_EN
    test_small_dc(5, 1);
`else
    test_small_dc(5, 0);
`endif
    test_small_dc(-5, -1);
    test_gapped();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
